// File: rtl/spi_flash_responder_pkg.sv
// Shared types and constants for the SPI flash responder model.
// Holds the controller state encoding and the command/address frame sizes.
package spi_flash_responder_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    DATA   = 3'd3,
    IGNORE = 3'd4
  } state_t;

  localparam logic [7:0] READ_CMD_DEF = 8'h03;
  localparam int         CMD_BITS     = 8;
  localparam int         ADDR_BITS    = 24;

endpackage

// File: rtl/spi_flash_responder_in_sync.sv
// Oversampling front end: synchronises spi_clk, csb and mosi into clk and
// derives single-cycle SCLK rise/fall and CSB fall events.
module spi_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic spi_clk,
  input  logic csb,
  input  logic mosi,
  output logic clk_rise,
  output logic clk_fall,
  output logic csb_s,
  output logic csb_fall,
  output logic mosi_s
);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] csb_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] vld;
  logic                   clk_d;
  logic                   csb_d;

  // Synchroniser chains plus the edge-detect flops; vld marks a chain filled
  // with real pin samples so a CSB already low at reset release is no fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= '0;
      csb_sync  <= '1;
      mosi_sync <= '0;
      vld       <= '0;
      clk_d     <= 1'b0;
      csb_d     <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], spi_clk};
      csb_sync  <= {csb_sync[SYNC_STAGES-2:0], csb};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      vld       <= {vld[SYNC_STAGES-2:0], 1'b1};
      clk_d     <= clk_sync[SYNC_STAGES-1];
      csb_d     <= csb_sync[SYNC_STAGES-1] & vld[SYNC_STAGES-1];
    end
  end

  assign clk_rise = clk_sync[SYNC_STAGES-1] & ~clk_d;
  assign clk_fall = ~clk_sync[SYNC_STAGES-1] & clk_d;
  assign csb_s    = csb_sync[SYNC_STAGES-1];
  assign csb_fall = csb_d & ~csb_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash responder: answers READ with a 24-bit address and streams
// bytes MSB-first from a synchronous-read memory, auto-incrementing the address.
module spi_flash_responder
  import spi_flash_responder_pkg::*;
#(
  parameter int         MEM_AW      = 8,
  parameter logic [7:0] READ_CMD    = READ_CMD_DEF,
  parameter int         SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_clk,
  input  logic              csb,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [MEM_AW-1:0] mem_addr_o,
  input  logic [7:0]        mem_rdata_i,
  output logic              busy_o,
  output logic              cmd_err_o,
  output logic [15:0]       bytes_sent_o
);

  localparam logic [4:0]        CMD_LAST  = 5'(CMD_BITS - 1);
  localparam logic [4:0]        ADDR_LAST = 5'(ADDR_BITS - 1);
  localparam logic [4:0]        BYTE_LAST = 5'd7;
  localparam logic [MEM_AW-1:0] ADDR_ONE  = MEM_AW'(1);

  logic clk_rise;
  logic clk_fall;
  logic csb_s;
  logic csb_fall;
  logic mosi_s;

  state_t              state, state_n;
  logic [4:0]          bit_cnt, bit_cnt_n;
  logic [CMD_BITS-2:0] cmd_sr, cmd_sr_n;
  logic [MEM_AW-2:0]   addr_sr, addr_sr_n;
  logic [7:0]          tx_sr, tx_sr_n;
  logic [7:0]          nxt_byte, nxt_byte_n;
  logic [MEM_AW-1:0]   mem_addr, mem_addr_n;
  logic [15:0]         bytes_sent, bytes_sent_n;
  logic                busy, busy_n;
  logic                oe, oe_n;
  logic                cmd_err, cmd_err_n;
  logic [1:0]          ld_tx, ld_tx_n;
  logic [1:0]          ld_nxt, ld_nxt_n;
  logic                skip_fall, skip_fall_n;
  logic [7:0]          cmd_full;
  logic [MEM_AW-1:0]   addr_full;

  spi_in_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .spi_clk  (spi_clk),
    .csb      (csb),
    .mosi     (mosi),
    .clk_rise (clk_rise),
    .clk_fall (clk_fall),
    .csb_s    (csb_s),
    .csb_fall (csb_fall),
    .mosi_s   (mosi_s)
  );

  // Only the address bits that can reach the memory are kept.
  assign cmd_full  = {cmd_sr, mosi_s};
  assign addr_full = {addr_sr, mosi_s};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Datapath registers; every output is driven straight from one of these.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt    <= 5'd0;
      cmd_sr     <= '0;
      addr_sr    <= '0;
      tx_sr      <= 8'h00;
      nxt_byte   <= 8'h00;
      mem_addr   <= '0;
      bytes_sent <= 16'h0000;
      busy       <= 1'b0;
      oe         <= 1'b0;
      cmd_err    <= 1'b0;
      ld_tx      <= 2'b00;
      ld_nxt     <= 2'b00;
      skip_fall  <= 1'b0;
    end else begin
      bit_cnt    <= bit_cnt_n;
      cmd_sr     <= cmd_sr_n;
      addr_sr    <= addr_sr_n;
      tx_sr      <= tx_sr_n;
      nxt_byte   <= nxt_byte_n;
      mem_addr   <= mem_addr_n;
      bytes_sent <= bytes_sent_n;
      busy       <= busy_n;
      oe         <= oe_n;
      cmd_err    <= cmd_err_n;
      ld_tx      <= ld_tx_n;
      ld_nxt     <= ld_nxt_n;
      skip_fall  <= skip_fall_n;
    end
  end

  // Next-state and datapath logic; ld_tx/ld_nxt are two-clk fetch delays
  // covering the one-clk memory read latency plus the registered address.
  always_comb begin
    state_n      = state;
    bit_cnt_n    = bit_cnt;
    cmd_sr_n     = cmd_sr;
    addr_sr_n    = addr_sr;
    tx_sr_n      = tx_sr;
    nxt_byte_n   = nxt_byte;
    mem_addr_n   = mem_addr;
    bytes_sent_n = bytes_sent;
    busy_n       = busy;
    oe_n         = oe;
    cmd_err_n    = 1'b0;
    ld_tx_n      = {ld_tx[0], 1'b0};
    ld_nxt_n     = {ld_nxt[0], 1'b0};
    skip_fall_n  = skip_fall;

    case (state)
      IDLE: begin
        if (csb_fall) begin
          state_n      = CMD;
          bit_cnt_n    = 5'd0;
          cmd_sr_n     = '0;
          addr_sr_n    = '0;
          tx_sr_n      = 8'h00;
          bytes_sent_n = 16'h0000;
          busy_n       = 1'b1;
          oe_n         = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      CMD: begin
        if (clk_rise) begin
          cmd_sr_n = cmd_full[CMD_BITS-2:0];
          if (bit_cnt == CMD_LAST) begin
            bit_cnt_n = 5'd0;
            if (cmd_full == READ_CMD) begin
              state_n = ADDR;
            end else begin
              state_n   = IGNORE;
              cmd_err_n = 1'b1;
            end
          end else begin
            bit_cnt_n = bit_cnt + 5'd1;
          end
        end else begin
          state_n = CMD;
        end
      end
      ADDR: begin
        if (clk_rise) begin
          addr_sr_n = addr_full[MEM_AW-2:0];
          if (bit_cnt == ADDR_LAST) begin
            bit_cnt_n   = 5'd0;
            mem_addr_n  = addr_full;
            ld_tx_n[0]  = 1'b1;
            skip_fall_n = 1'b1;
            state_n     = DATA;
          end else begin
            bit_cnt_n = bit_cnt + 5'd1;
          end
        end else begin
          state_n = ADDR;
        end
      end
      DATA: begin
        if (ld_tx[1]) begin
          tx_sr_n     = mem_rdata_i;
          mem_addr_n  = mem_addr + ADDR_ONE;
          ld_nxt_n[0] = 1'b1;
        end else begin
          tx_sr_n = tx_sr;
        end
        if (ld_nxt[1]) begin
          nxt_byte_n = mem_rdata_i;
        end else begin
          nxt_byte_n = nxt_byte;
        end
        // The fall right after the last address bit must not disturb bit 7.
        if (clk_fall) begin
          if (skip_fall) begin
            skip_fall_n = 1'b0;
          end else if (bit_cnt == BYTE_LAST) begin
            bit_cnt_n    = 5'd0;
            tx_sr_n      = nxt_byte;
            mem_addr_n   = mem_addr + ADDR_ONE;
            ld_nxt_n[0]  = 1'b1;
            bytes_sent_n = (bytes_sent == 16'hFFFF) ? bytes_sent : bytes_sent + 16'd1;
          end else begin
            bit_cnt_n = bit_cnt + 5'd1;
            tx_sr_n   = {tx_sr[6:0], 1'b0};
          end
        end else begin
          state_n = DATA;
        end
      end
      IGNORE: begin
        tx_sr_n = 8'h00;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // CSB deselect beats any simultaneous SCLK event; partial frames vanish.
    if (csb_s && (state != IDLE)) begin
      state_n      = IDLE;
      bit_cnt_n    = 5'd0;
      tx_sr_n      = 8'h00;
      mem_addr_n   = mem_addr;
      bytes_sent_n = bytes_sent;
      busy_n       = 1'b0;
      oe_n         = 1'b0;
      cmd_err_n    = 1'b0;
      ld_tx_n      = 2'b00;
      ld_nxt_n     = 2'b00;
      skip_fall_n  = 1'b0;
    end else begin
      busy_n = busy_n;
    end
  end

  assign miso         = tx_sr[7];
  assign miso_oe      = oe;
  assign mem_addr_o   = mem_addr;
  assign busy_o       = busy;
  assign cmd_err_o    = cmd_err;
  assign bytes_sent_o = bytes_sent;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Self-checking bench: a bench-side SPI master and memory drive the responder;
// expected bytes come from the memory array and plain address arithmetic.
module tb_spi_flash_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_clk;
  logic        csb;
  logic        mosi;
  logic        miso;
  logic        miso_oe;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_rdata = 8'h00;
  logic        busy;
  logic        cmd_err;
  logic [15:0] bytes_sent;

  logic [7:0]  mem [256];
  int          checks;
  int          errors;
  int          err_pulses = 0;
  int          err_high = 0;
  logic        err_prev = 1'b0;
  int          exp_pulses;

  logic [7:0]  d;
  logic        b;
  logic        acc_miso;
  logic        acc_busy;
  logic [23:0] a;
  int          h;
  int          n;

  always #5 clk = ~clk;

  spi_flash_responder dut (
    .clk          (clk),
    .rst          (rst),
    .spi_clk      (spi_clk),
    .csb          (csb),
    .mosi         (mosi),
    .miso         (miso),
    .miso_oe      (miso_oe),
    .mem_addr_o   (mem_addr),
    .mem_rdata_i  (mem_rdata),
    .busy_o       (busy),
    .cmd_err_o    (cmd_err),
    .bytes_sent_o (bytes_sent)
  );

  always @(posedge clk) mem_rdata <= mem[mem_addr];

  always @(negedge clk) begin
    if (cmd_err && !err_prev) err_pulses <= err_pulses + 1;
    if (cmd_err) err_high <= err_high + 1;
    err_prev <= cmd_err;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int cnt);
    repeat (cnt) @(negedge clk);
  endtask

  task automatic xfer_bit(input logic mo, input int hp, output logic mi);
    mosi = mo;
    wait_clk(hp);
    spi_clk = 1'b1;
    mi = miso;
    wait_clk(hp);
    spi_clk = 1'b0;
  endtask

  task automatic xfer_byte(input logic [7:0] mo, input int hp, output logic [7:0] mi);
    logic bit_in;
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(mo[i], hp, bit_in);
      mi[i] = bit_in;
    end
  endtask

  task automatic begin_txn(input logic [7:0] cmd, input logic [23:0] addr, input int hp);
    logic [7:0] junk;
    csb = 1'b0;
    wait_clk(4);
    xfer_byte(cmd, hp, junk);
    xfer_byte(addr[23:16], hp, junk);
    xfer_byte(addr[15:8], hp, junk);
    xfer_byte(addr[7:0], hp, junk);
  endtask

  task automatic end_txn(input int hp);
    wait_clk(hp);
    csb = 1'b1;
    wait_clk(8);
  endtask

  function automatic logic [7:0] model_byte(input logic [23:0] addr, input int k);
    logic [7:0] idx;
    idx = addr[7:0] + 8'(k);
    return mem[idx];
  endfunction

  initial begin
    logic [7:0] lit [4];
    lit = '{8'hB5, 8'hB4, 8'hB7, 8'hB6};
    checks = 0;
    errors = 0;
    exp_pulses = 0;
    rst = 1'b1;
    csb = 1'b1;
    spi_clk = 1'b0;
    mosi = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
    wait_clk(3);
    check_eq("rst_miso", {31'd0, miso}, 32'd0);
    check_eq("rst_oe", {31'd0, miso_oe}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_err", {31'd0, cmd_err}, 32'd0);
    check_eq("rst_bytes", {16'd0, bytes_sent}, 32'd0);
    check_eq("rst_addr", {24'd0, mem_addr}, 32'd0);
    rst = 1'b0;
    wait_clk(4);

    // Four-byte read from 0x10
    begin_txn(8'h03, 24'h000010, 5);
    check_eq("rd4_busy", {31'd0, busy}, 32'd1);
    check_eq("rd4_oe", {31'd0, miso_oe}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      xfer_byte(8'h00, 5, d);
      check_eq("rd4_byte", {24'd0, d}, {24'd0, lit[k]});
    end
    end_txn(5);
    check_eq("rd4_count", {16'd0, bytes_sent}, 32'd4);
    check_eq("rd4_idle_busy", {31'd0, busy}, 32'd0);
    check_eq("rd4_idle_oe", {31'd0, miso_oe}, 32'd0);
    check_eq("rd4_addr", {24'd0, mem_addr}, 32'h15);
    check_eq("rd4_no_err", err_pulses, exp_pulses);

    // Address wrap 0xFF -> 0x00
    begin_txn(8'h03, 24'h0000FF, 5);
    wait_clk(2);
    check_eq("wrap_prefetch_addr", {24'd0, mem_addr}, 32'h00);
    for (int k = 0; k < 2; k++) begin
      xfer_byte(8'h00, 5, d);
      check_eq("wrap_byte", {24'd0, d}, {24'd0, model_byte(24'h0000FF, k)});
    end
    end_txn(5);
    check_eq("wrap_count", {16'd0, bytes_sent}, 32'd2);
    check_eq("wrap_addr", {24'd0, mem_addr}, 32'h02);

    // Bad opcode 0x0B
    begin
      int hi0;
      hi0 = err_high;
      exp_pulses++;
      csb = 1'b0;
      wait_clk(4);
      xfer_byte(8'h0B, 5, d);
      wait_clk(4);
      check_eq("bad_err_pulse", err_pulses, exp_pulses);
      check_eq("bad_err_width", err_high - hi0, 32'd1);
      acc_miso = 1'b0;
      for (int i = 0; i < 32; i++) begin
        xfer_bit(1'($urandom), 5, b);
        acc_miso = acc_miso | b;
      end
      check_eq("bad_miso_zero", {31'd0, acc_miso}, 32'd0);
      end_txn(5);
      check_eq("bad_count", {16'd0, bytes_sent}, 32'd0);
      check_eq("bad_single_err", err_pulses, exp_pulses);
    end

    // Abort after three bits of byte 2
    begin_txn(8'h03, 24'h000020, 5);
    xfer_byte(8'h00, 5, d);
    check_eq("abort_byte0", {24'd0, d}, {24'd0, model_byte(24'h000020, 0)});
    for (int i = 0; i < 3; i++) xfer_bit(1'b0, 5, b);
    csb = 1'b1;
    wait_clk(4);
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    check_eq("abort_oe", {31'd0, miso_oe}, 32'd0);
    check_eq("abort_count", {16'd0, bytes_sent}, 32'd1);
    wait_clk(6);
    begin_txn(8'h03, 24'h000030, 5);
    xfer_byte(8'h00, 5, d);
    check_eq("abort_restart", {24'd0, d}, {24'd0, model_byte(24'h000030, 0)});
    end_txn(5);
    check_eq("abort_restart_cnt", {16'd0, bytes_sent}, 32'd1);

    // Minimum SCLK phases, random memory
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    begin_txn(8'h03, 24'h000042, 4);
    for (int k = 0; k < 2; k++) begin
      xfer_byte(8'h00, 4, d);
      check_eq("min_sclk_byte", {24'd0, d}, {24'd0, model_byte(24'h000042, k)});
    end
    end_txn(4);
    check_eq("min_sclk_count", {16'd0, bytes_sent}, 32'd2);

    // Asynchronous reset in the middle of DATA
    mem[8'h50] = 8'hFF;
    mem[8'h51] = 8'hFF;
    begin_txn(8'h03, 24'h000050, 5);
    xfer_bit(1'b0, 5, b);
    xfer_bit(1'b0, 5, b);
    wait_clk(1);
    check_eq("pre_rst_miso", {31'd0, miso}, 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check_eq("arst_miso", {31'd0, miso}, 32'd0);
    check_eq("arst_oe", {31'd0, miso_oe}, 32'd0);
    check_eq("arst_busy", {31'd0, busy}, 32'd0);
    check_eq("arst_count", {16'd0, bytes_sent}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    acc_miso = 1'b0;
    acc_busy = 1'b0;
    for (int i = 0; i < 16; i++) begin
      xfer_bit(1'b1, 5, b);
      acc_miso = acc_miso | b | miso_oe;
      acc_busy = acc_busy | busy;
    end
    check_eq("post_rst_silent", {31'd0, acc_miso}, 32'd0);
    check_eq("post_rst_idle", {31'd0, acc_busy}, 32'd0);
    csb = 1'b1;
    wait_clk(8);
    begin_txn(8'h03, 24'h000050, 5);
    xfer_byte(8'h00, 5, d);
    check_eq("post_rst_read", {24'd0, d}, 32'hFF);
    end_txn(5);

    // Randomized reads
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      a = 24'($urandom);
      n = $urandom_range(1, 4);
      h = $urandom_range(4, 6);
      begin_txn(8'h03, a, h);
      for (int k = 0; k < n; k++) begin
        xfer_byte(8'($urandom), h, d);
        check_eq("rand_byte", {24'd0, d}, {24'd0, model_byte(a, k)});
      end
      end_txn(h);
      check_eq("rand_count", {16'd0, bytes_sent}, 32'(n));
      check_eq("rand_addr", {24'd0, mem_addr}, {24'd0, a[7:0] + 8'(n + 1)});
    end
    check_eq("final_err_pulses", err_pulses, exp_pulses);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_flash_responder.md
Name: spi_flash_responder

Overview:
- SPI mode-0 responder that models the external flash device, i.e. the far end of the flash SPI master link.
- Decodes READ (0x03) plus a 24-bit address.
- Streams bytes MSB-first from a synchronous-read memory port, auto-incrementing the address for as long as CSB stays low.
- Used as the on-chip / bench flash model behind the flash master's spi_clk, csb, mosi and miso pins.
- Everything runs in the system clock domain; SPI inputs are oversampled.

Parameters:
- MEM_AW, 8, memory address width; the low MEM_AW bits of the 24-bit SPI address select the word and upper bits are ignored.
- READ_CMD, 8'h03, the only opcode that is answered.
- SYNC_STAGES, 2, synchroniser flops on spi_clk, csb and mosi.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- spi_clk  in  1  SCLK from the master; idles low (mode 0).
- csb  in  1  chip select, active-low.
- mosi  in  1  master-out data.
- miso  out  1  responder data to the master.
- miso_oe  out  1  high while selected; pad enable.
- mem_addr_o  out  MEM_AW  memory read address.
- mem_rdata_i  in  8  memory data, valid one clk after mem_addr_o.
- busy_o  out  1  high from CSB fall until CSB rise.
- cmd_err_o  out  1  one-clk pulse when the opcode is not READ_CMD.
- bytes_sent_o  out  16  data bytes completed in the current or last transaction; saturates at 16'hFFFF.

Behaviour:
- Reset (async, rst=1): every output 0 except miso=0 and miso_oe=0; state IDLE; shift registers, counters and synchroniser flops cleared; synchroniser csb flops reset to 1.
- Input sampling:
  - spi_clk, csb and mosi pass through SYNC_STAGES flops.
  - Edge detect uses one further flop.
  - A rise or fall event is therefore seen SYNC_STAGES+1 clk after the pin edge.
- Legal SCLK: high and low phases each ≥ 4 clk periods; faster SCLK is out of spec.
- States:
  - IDLE: csb_s high. csb_s fall → CMD, bit_cnt=0, bytes_sent_o=0, busy_o=1, miso_oe=1.
  - CMD: on each rise, shift mosi_s into cmd_sr. After the 8th rise: if cmd_sr==READ_CMD → ADDR, else → IGNORE with cmd_err_o pulsed for 1 clk.
  - ADDR: 24 rises shift into addr_sr. On the rise event of the 24th bit:
    - mem_addr_o ← addr_sr[MEM_AW-1:0] including the final bit.
    - The next clk, tx_sr ← mem_rdata_i and miso = tx_sr[7].
    - mem_addr_o ← address+1, the prefetch; the following clk, nxt_byte ← mem_rdata_i.
    - → DATA.
    - The first data bit is stable before the master's following falling edge; the master samples it on the next rise.
  - DATA: each fall event shifts tx_sr left by 1, bit_cnt+1 modulo 8.
    - When bit_cnt wraps 7→0: tx_sr ← nxt_byte, bytes_sent_o+1 (saturating), mem_addr_o+1, and nxt_byte is reloaded one clk later.
    - Address wraps modulo 2^MEM_AW.
    - Rise events are ignored.
  - IGNORE: miso held 0; all SCLK activity ignored.
- CSB rise in any state: next clk → IDLE, busy_o=0, miso_oe=0, miso=0, and any partial byte is discarded.
  - bytes_sent_o holds its value until the next CSB fall.
  - A partial command or address produces no memory access and no cmd_err_o.
- Simultaneous csb_s rise and SCLK edge in the same clk: CSB wins and the edge is ignored.
- In IDLE, mem_addr_o holds its last value.
- miso changes only on fall events or when a byte is loaded, never on rise events.

Decomposition:
- Shared package holds:
  - state enum {IDLE, CMD, ADDR, DATA, IGNORE};
  - READ_CMD default 8'h03;
  - CMD_BITS=8, ADDR_BITS=24.
- One sub-module, spi_in_sync: an SYNC_STAGES-deep synchroniser plus edge detector for spi_clk, csb and mosi. It outputs clk_rise, clk_fall, csb_s, csb_fall and mosi_s.

Test Plan:
- Read 4 bytes: memory preloaded mem[i]=i^8'hA5; CSB low, send 03 00 00 10, clock 32 SCLK → master receives A5^10, A5^11, A5^12, A5^13 (B5 B4 B7 B6); bytes_sent_o=4; cmd_err_o never pulses.
- Wrap-around: address 00 00 FF with MEM_AW=8, read 2 bytes → mem[FF] then mem[00]; mem_addr_o goes FF→00.
- Bad opcode 0x0B: cmd_err_o pulses once after the 8th rise; miso=0 for the next 32 SCLK; bytes_sent_o=0.
- Abort mid-byte: CSB rises after 3 data bits of byte 2 → busy_o=0 and miso_oe=0 within SYNC_STAGES+2 clk; bytes_sent_o=1; the next transaction restarts cleanly in CMD.
- Async reset mid-DATA: rst pulsed high between clk edges → miso, miso_oe and busy_o go 0 immediately; after release with CSB held low, nothing is sent until a fresh CSB fall.
- Minimum SCLK timing: 4-clk high and 4-clk low phases, 2-byte read from address 0x000042 → data matches mem[42] and mem[43] bit-exact.
